// File: rtl/load_store_unit_if.sv
// Core-side request/writeback and data-memory strobe signals of the load/store unit.
// The slave modport is the unit's view; the master modport is the core/memory side.
interface load_store_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int REG_W  = 3
);
  logic              req;
  logic              is_load;
  logic              is_store;
  logic [15:0]       addr;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  dest_reg;
  logic              busy;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_reg;
  logic              st_ack;
  logic              fault;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  req, is_load, is_store, addr, store_data, dest_reg, mem_data_out,
    output busy, wb_valid, wb_data, wb_reg, st_ack, fault,
           mem_wr_en, mem_rd_en, mem_address, mem_data_in
  );

  modport master (
    output req, is_load, is_store, addr, store_data, dest_reg, mem_data_out,
    input  busy, wb_valid, wb_data, wb_reg, st_ack, fault,
           mem_wr_en, mem_rd_en, mem_address, mem_data_in
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: range-checks the effective address, strobes a
// registered-read data memory for one cycle, and returns load data with its register tag.
//
// state   | meaning
// IDLE    | waiting for req; faults are reported without leaving IDLE
// ISSUE   | one memory strobe is high this cycle
// CAPTURE | load data is on mem_data_out; written back at the next edge
module load_store_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic [REG_W-1:0]  tag_q, tag_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
  logic              st_ack_q, st_ack_d;
  logic              fault_q, fault_d;

  logic accept, range_ok, enc_ok;

  assign accept   = bus.req && !busy_q;
  assign range_ok = (bus.addr[15:ADDR_W] == '0);
  assign enc_ok   = bus.is_load ^ bus.is_store;

  always_comb begin
    state_d       = state_q;
    mem_wr_en_d   = 1'b0;
    mem_rd_en_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    tag_d         = tag_q;
    wb_valid_d    = 1'b0;
    wb_data_d     = wb_data_q;
    wb_reg_d      = wb_reg_q;
    st_ack_d      = 1'b0;
    fault_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!range_ok || !enc_ok) begin
            fault_d = 1'b1;
          end else begin
            mem_address_d = bus.addr[ADDR_W-1:0];
            mem_data_in_d = bus.store_data;
            tag_d         = bus.dest_reg;
            mem_wr_en_d   = bus.is_store;
            mem_rd_en_d   = bus.is_load;
            state_d       = ISSUE;
          end
        end
      end
      ISSUE: begin
        // The write strobe still being high tells us which kind of access is in flight.
        if (mem_wr_en_q) begin
          st_ack_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        wb_valid_d = 1'b1;
        wb_data_d  = bus.mem_data_out;
        wb_reg_d   = tag_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      tag_q         <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_reg_q      <= '0;
      st_ack_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      tag_q         <= tag_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_reg_q      <= wb_reg_d;
      st_ack_q      <= st_ack_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_reg      = wb_reg_q;
  assign bus.st_ack      = st_ack_q;
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random bench for load_store_unit with a behavioural 64-word registered memory
// and a scoreboard of expected completions (load data, store ack, fault).
module tb_load_store_unit;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int REG_W  = 3;

  localparam logic [1:0] K_LD  = 2'd0;
  localparam logic [1:0] K_ST  = 2'd1;
  localparam logic [1:0] K_FLT = 2'd2;

  typedef struct {
    logic [1:0]        kind;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic [DATA_W-1:0] mem_model [64];
  logic [DATA_W-1:0] ref_mem   [64];

  load_store_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) b ();

  load_store_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  always #5 clk = ~clk;

  // Data memory: registered write and registered read.
  always @(posedge clk) begin
    if (b.mem_wr_en) mem_model[b.mem_address] <= b.mem_data_in;
    if (b.mem_rd_en) b.mem_data_out <= mem_model[b.mem_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor and strobe rules.
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_wr = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (b.wb_valid || b.st_ack || b.fault) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          logic [1:0] k;
          e = sb.pop_front();
          k = b.wb_valid ? K_LD : (b.st_ack ? K_ST : K_FLT);
          check("sb_kind", {30'd0, k}, {30'd0, e.kind});
          if (k == K_LD) begin
            check("sb_wb_data", {16'd0, b.wb_data}, {16'd0, e.data});
            check("sb_wb_reg", {29'd0, b.wb_reg}, {29'd0, e.rg});
          end
        end
      end
      if (b.mem_wr_en || b.mem_rd_en) check("strobe_exclusive", {31'd0, b.mem_wr_en && b.mem_rd_en}, 32'd0);
      if (b.mem_wr_en) check("wr_strobe_one_cycle", {31'd0, prev_wr}, 32'd0);
      if (b.mem_rd_en) check("rd_strobe_one_cycle", {31'd0, prev_rd}, 32'd0);
      prev_wr = b.mem_wr_en;
      prev_rd = b.mem_rd_en;
    end
  end

  task automatic drive(input logic ld, input logic st, input logic [15:0] a,
                       input logic [DATA_W-1:0] d, input logic [REG_W-1:0] t);
    b.req        = 1'b1;
    b.is_load    = ld;
    b.is_store   = st;
    b.addr       = a;
    b.store_data = d;
    b.dest_reg   = t;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (b.busy && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (b.busy) check("idle_timeout", {31'd0, b.busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_model[i] = '0;
      ref_mem[i]   = '0;
    end
    b.req = 1'b0; b.is_load = 1'b0; b.is_store = 1'b0;
    b.addr = '0; b.store_data = '0; b.dest_reg = '0;

    // Reset values
    #12;
    check("rst_busy", {31'd0, b.busy}, 32'd0);
    check("rst_wb_valid", {31'd0, b.wb_valid}, 32'd0);
    check("rst_mem_address", {26'd0, b.mem_address}, 32'd0);
    check("rst_wb_data", {16'd0, b.wb_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Store 0x0005 <= 0xBEEF
    drive(1'b0, 1'b1, 16'h0005, 16'hBEEF, 3'd0);
    sb.push_back('{K_ST, 16'h0, 3'd0});
    ref_mem[5] = 16'hBEEF;
    @(negedge clk);
    b.req = 1'b0;
    check("st_wr_en", {31'd0, b.mem_wr_en}, 32'd1);
    check("st_rd_en", {31'd0, b.mem_rd_en}, 32'd0);
    check("st_address", {26'd0, b.mem_address}, 32'd5);
    check("st_data_in", {16'd0, b.mem_data_in}, 32'h0000BEEF);
    check("st_busy", {31'd0, b.busy}, 32'd1);
    check("st_ack_early", {31'd0, b.st_ack}, 32'd0);
    @(negedge clk);
    check("st_ack", {31'd0, b.st_ack}, 32'd1);
    check("st_wr_drop", {31'd0, b.mem_wr_en}, 32'd0);
    check("st_busy_drop", {31'd0, b.busy}, 32'd0);
    check("st_addr_hold", {26'd0, b.mem_address}, 32'd5);

    // Load 0x0005 -> r3
    drive(1'b1, 1'b0, 16'h0005, 16'h0000, 3'd3);
    sb.push_back('{K_LD, ref_mem[5], 3'd3});
    @(negedge clk);
    b.req = 1'b0;
    check("ld_rd_en", {31'd0, b.mem_rd_en}, 32'd1);
    check("ld_busy1", {31'd0, b.busy}, 32'd1);
    @(negedge clk);
    check("ld_rd_drop", {31'd0, b.mem_rd_en}, 32'd0);
    check("ld_busy2", {31'd0, b.busy}, 32'd1);
    check("ld_wb_early", {31'd0, b.wb_valid}, 32'd0);
    @(negedge clk);
    check("ld_wb_valid", {31'd0, b.wb_valid}, 32'd1);
    check("ld_wb_data", {16'd0, b.wb_data}, 32'h0000BEEF);
    check("ld_wb_reg", {29'd0, b.wb_reg}, 32'd3);
    check("ld_busy_drop", {31'd0, b.busy}, 32'd0);
    @(negedge clk);
    check("ld_wb_pulse", {31'd0, b.wb_valid}, 32'd0);
    check("ld_wb_data_hold", {16'd0, b.wb_data}, 32'h0000BEEF);

    // Out-of-range load, then bad encoding
    drive(1'b1, 1'b0, 16'h0040, 16'h0000, 3'd1);
    sb.push_back('{K_FLT, 16'h0, 3'd0});
    @(negedge clk);
    b.req = 1'b0;
    check("rng_fault", {31'd0, b.fault}, 32'd1);
    check("rng_no_rd", {31'd0, b.mem_rd_en}, 32'd0);
    check("rng_busy", {31'd0, b.busy}, 32'd0);
    drive(1'b1, 1'b1, 16'h0001, 16'h0000, 3'd1);
    sb.push_back('{K_FLT, 16'h0, 3'd0});
    @(negedge clk);
    b.req = 1'b0;
    check("enc_fault", {31'd0, b.fault}, 32'd1);
    check("enc_no_wr", {31'd0, b.mem_wr_en}, 32'd0);
    @(negedge clk);
    check("fault_pulse", {31'd0, b.fault}, 32'd0);

    // req held: store 0x3F <= 0x1234 then load 0x3F -> r5
    drive(1'b0, 1'b1, 16'h003F, 16'h1234, 3'd0);
    sb.push_back('{K_ST, 16'h0, 3'd0});
    ref_mem[63] = 16'h1234;
    @(negedge clk);
    check("b2b_st_wr", {31'd0, b.mem_wr_en}, 32'd1);
    drive(1'b1, 1'b0, 16'h003F, 16'h5555, 3'd5);
    sb.push_back('{K_LD, 16'h1234, 3'd5});
    @(negedge clk);
    check("b2b_st_ack", {31'd0, b.st_ack}, 32'd1);
    check("b2b_no_rd_yet", {31'd0, b.mem_rd_en}, 32'd0);
    @(negedge clk);
    check("b2b_ld_rd", {31'd0, b.mem_rd_en}, 32'd1);
    check("b2b_ld_addr", {26'd0, b.mem_address}, 32'd63);
    drive(1'b0, 1'b1, 16'h0007, 16'hDEAD, 3'd0);
    @(negedge clk);
    b.req = 1'b0;
    check("busy_req_ignored", {31'd0, b.mem_wr_en}, 32'd0);
    @(negedge clk);
    check("b2b_wb_data", {16'd0, b.wb_data}, 32'h00001234);
    check("b2b_wb_reg", {29'd0, b.wb_reg}, 32'd5);
    @(negedge clk);
    check("ignored_no_wr", {31'd0, b.mem_wr_en}, 32'd0);

    // Reset during CAPTURE of a load
    drive(1'b1, 1'b0, 16'h003F, 16'h0000, 3'd2);
    sb.push_back('{K_LD, 16'h1234, 3'd2});
    @(negedge clk);
    b.req = 1'b0;
    @(negedge clk);
    check("capt_busy", {31'd0, b.busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, b.busy}, 32'd0);
    check("arst_wb_valid", {31'd0, b.wb_valid}, 32'd0);
    check("arst_wb_data", {16'd0, b.wb_data}, 32'd0);
    check("arst_address", {26'd0, b.mem_address}, 32'd0);
    check("arst_data_in", {16'd0, b.mem_data_in}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_no_wb", {31'd0, b.wb_valid}, 32'd0);
    drive(1'b1, 1'b0, 16'h003F, 16'h0000, 3'd6);
    sb.push_back('{K_LD, 16'h1234, 3'd6});
    @(negedge clk);
    b.req = 1'b0;
    wait_idle();
    check("post_rst_wb_reg", {29'd0, b.wb_reg}, 32'd6);
    check("post_rst_wb_data", {16'd0, b.wb_data}, 32'h00001234);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      logic [15:0] a;
      logic [DATA_W-1:0] d;
      logic [REG_W-1:0] t;
      r = int'($urandom_range(0, 19));
      a = (r == 0) ? 16'(64 + $urandom_range(0, 65000)) : 16'($urandom_range(0, 63));
      d = 16'($urandom);
      t = 3'($urandom_range(0, 7));
      if (r == 0) begin
        drive(1'b0, 1'b1, a, d, t);
        sb.push_back('{K_FLT, 16'h0, 3'd0});
      end else if (r == 1) begin
        drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), a, d, t);
        if (b.is_load == b.is_store) sb.push_back('{K_FLT, 16'h0, 3'd0});
        else if (b.is_store) begin
          ref_mem[a[5:0]] = d;
          sb.push_back('{K_ST, 16'h0, 3'd0});
        end else sb.push_back('{K_LD, ref_mem[a[5:0]], t});
      end else if (r < 11) begin
        drive(1'b0, 1'b1, a, d, t);
        ref_mem[a[5:0]] = d;
        sb.push_back('{K_ST, 16'h0, 3'd0});
      end else begin
        drive(1'b1, 1'b0, a, d, t);
        sb.push_back('{K_LD, ref_mem[a[5:0]], t});
      end
      @(negedge clk);
      b.req = 1'b0;
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
